seven_seg_scan_n: RTL and testbench

- Parametrised N-digit multiplexed seven-segment display driver, single clock domain.
- Generalises the fixed 4-digit, separately clocked display path of the processor top level.
- Internal refresh prescaler; per-digit blank and decimal-point control.
- Tear-free double-buffered value load, applied only at frame boundaries.

---
 rtl/seven_seg_scan_n.sv | 188 ++++++++++++++++++
 tb/tb_seven_seg_scan_n.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_n.sv
// seven_seg_scan_n: N-digit multiplexed seven-segment display driver.
// An internal prescaler paces the digit scan. Loads are double-buffered so
// the displayed value only changes at a frame boundary, which prevents tearing.
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seven_seg_scan_n #(
  parameter  int NUM_DIGITS = 4,
  parameter  int CLK_DIV    = 50000,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seven_segment,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_digit_idx;
  logic                    r_frame_done;

  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_en;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;

  logic [4*NUM_DIGITS-1:0] r_disp_value;
  logic [NUM_DIGITS-1:0]   r_disp_en;
  logic [NUM_DIGITS-1:0]   r_disp_dp;

  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;
  logic                    r_dp_n;

  logic                    w_tick;
  logic                    w_last_digit;
  logic                    w_boundary;
  logic [3:0]              w_nib;
  logic                    w_en;
  logic                    w_dp;
  logic                    w_lz;
  logic [NUM_DIGITS-1:0]   w_anode_sel;
  logic [NUM_DIGITS-1:0]   w_lz_blank;

  assign w_tick       = (r_presc == CNT_W'(CLK_DIV - 1));
  assign w_last_digit = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_boundary   = w_tick && w_last_digit;

  // Prescaler and digit index: hold each digit for CLK_DIV cycles, wrap at the last digit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_presc     <= '0;
      r_digit_idx <= '0;
    end else if (w_tick) begin
      r_presc     <= '0;
      r_digit_idx <= w_last_digit ? '0 : r_digit_idx + IDX_W'(1);
    end else begin
      r_presc     <= r_presc + CNT_W'(1);
    end
  end

  // Double buffer: loads park in the pending buffer and are promoted at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_pend_value <= '0;
      r_pend_en    <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_disp_value <= '0;
      r_disp_en    <= '0;
      r_disp_dp    <= '0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_boundary) begin
        // A load landing on the boundary itself bypasses the pending buffer.
        if (load) begin
          r_disp_value <= value;
          r_disp_en    <= digit_en;
          r_disp_dp    <= dp_in;
        end else if (r_pend_valid) begin
          r_disp_value <= r_pend_value;
          r_disp_en    <= r_pend_en;
          r_disp_dp    <= r_pend_dp;
        end
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend_value <= value;
        r_pend_en    <= digit_en;
        r_pend_dp    <= dp_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Leading-zero blanking: suppress a zero digit when all higher enabled digits are zero.
  always_comb begin : lz_blk
    logic higher_zero;
    w_lz_blank  = '0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if ((i != 0) && (r_disp_value[i*4 +: 4] == 4'h0) && higher_zero)
        w_lz_blank[i] = 1'b1;
      if (r_disp_en[i] && (r_disp_value[i*4 +: 4] != 4'h0))
        higher_zero = 1'b0;
    end
  end
`else
  assign w_lz_blank = '0;
`endif

  // Select the addressed digit's nibble, enable, decimal point and anode pattern.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the loop leaves a value unassigned and infers a latch.
    w_nib       = 4'h0;
    w_en        = 1'b0;
    w_dp        = 1'b0;
    w_lz        = 1'b0;
    w_anode_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) begin
        w_nib          = r_disp_value[i*4 +: 4];
        w_en           = r_disp_en[i];
        w_dp           = r_disp_dp[i];
        w_lz           = w_lz_blank[i];
        w_anode_sel[i] = 1'b0;
      end
    end
  end

  // Registered output drive, one cycle behind digit_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode <= '1;
      r_seg   <= 7'h7F;
      r_dp_n  <= 1'b1;
    end else if (w_en && !w_lz) begin
      r_anode <= w_anode_sel;
      r_seg   <= hex_to_seg(w_nib);
      r_dp_n  <= ~w_dp;
    end else begin
      r_anode <= '1;
      r_seg   <= 7'h7F;
      r_dp_n  <= 1'b1;
    end
  end

  assign anode         = r_anode;
  assign seven_segment = r_seg;
  assign dp_n          = r_dp_n;
  assign digit_idx     = r_digit_idx;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed bench for seven_seg_scan_n (4 digits, CLK_DIV=4) plus a
// 1-digit, CLK_DIV=1 instance exercising the degenerate configuration.
module tb_seven_seg_scan_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [6:0]  seven_segment;
  logic        dp_n;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  logic [6:0]  seg1;
  logic        dp_n1;
  logic [0:0]  anode1;
  logic [0:0]  idx1;
  logic        frame_done1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seven_seg_scan_n #(.NUM_DIGITS(4), .CLK_DIV(4), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .value         (value),
    .load          (load),
    .digit_en      (digit_en),
    .dp_in         (dp_in),
    .seven_segment (seven_segment),
    .dp_n          (dp_n),
    .anode         (anode),
    .digit_idx     (digit_idx),
    .frame_done    (frame_done)
  );

  seven_seg_scan_n #(.NUM_DIGITS(1), .CLK_DIV(1), .CNT_W(1)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .value         (value[3:0]),
    .load          (load),
    .digit_en      (digit_en[0:0]),
    .dp_in         (dp_in[0:0]),
    .seven_segment (seg1),
    .dp_n          (dp_n1),
    .anode         (anode1),
    .digit_idx     (idx1),
    .frame_done    (frame_done1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the negedge where frame_done is high, bounded.
  task automatic wait_frame_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_done_seen", 16'(seen), 16'h1);
  endtask

  task automatic check_digit(input string tag, input logic [3:0] an,
                             input logic [6:0] seg, input logic dpn);
    check({tag, "_anode"}, 16'(anode), 16'(an));
    check({tag, "_seg"},   16'(seven_segment), 16'(seg));
    check({tag, "_dp_n"},  16'(dp_n), 16'(dpn));
  endtask

  logic [3:0] exp_an [4];
  logic [6:0] exp_seg[4];

  initial begin
    reset = 1'b1; value = '0; load = 1'b0; digit_en = '0; dp_in = '0;
    step(2);
    check_digit("reset", 4'hF, 7'h7F, 1'b1);
    check("reset_idx", 16'(digit_idx), 16'h0);
    check("reset_fd", 16'(frame_done), 16'h0);

    // Test 1: 12AF, all digits enabled, full scan.
    reset = 1'b0; value = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0; load = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame_done();
    check("d1_anode", 16'(anode1), 16'h0);
    check("d1_seg", 16'(seg1), 16'h0E);
    check("d1_fd", 16'(frame_done1), 16'h1);
    check("d1_idx", 16'(idx1), 16'h0);
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_seg[0] = 7'h0E; exp_seg[1] = 7'h08; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check_digit("scan", exp_an[(k-1)/4], exp_seg[(k-1)/4], 1'b1);
      check("scan_fd", 16'(frame_done), (k == 16) ? 16'h1 : 16'h0);
    end

    // Test 2: load mid-frame, old value kept until boundary.
    step(5);
    value = 16'h1234; load = 1'b1;
    step(1);
    load = 1'b0;
    check_digit("hold_old", 4'b1101, 7'h08, 1'b1);
    wait_frame_done();
    step(1);
    check_digit("new_d0", 4'b1110, 7'h19, 1'b1);

    // Test 3: two loads in one frame, last writer wins.
    value = 16'h1111; load = 1'b1;
    step(1);
    load = 1'b0;
    step(2);
    value = 16'h2222; load = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame_done();
    step(1);
    check_digit("lww_d0", 4'b1110, 7'h24, 1'b1);
    step(4);
    check_digit("lww_d1", 4'b1101, 7'h24, 1'b1);

    // Test 4: load coincident with the boundary tick.
    wait_frame_done();
    step(15);
    value = 16'h5678; load = 1'b1;
    step(1);
    load = 1'b0;
    check("bnd_fd", 16'(frame_done), 16'h1);
    check("bnd_pend", 16'(dut.r_pend_valid), 16'h0);
    step(1);
    check_digit("bnd_d0", 4'b1110, 7'h00, 1'b1);
    step(4);
    check_digit("bnd_d1", 4'b1101, 7'h78, 1'b1);

    // Test 5: per-digit blanking and decimal point.
    wait_frame_done();
    value = 16'h4321; digit_en = 4'b0101; dp_in = 4'b0001; load = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame_done();
    step(1);
    check_digit("en_d0", 4'b1110, 7'h79, 1'b0);
    step(4);
    check_digit("en_d1", 4'b1111, 7'h7F, 1'b1);
    step(4);
    check_digit("en_d2", 4'b1011, 7'h30, 1'b1);
    step(4);
    check_digit("en_d3", 4'b1111, 7'h7F, 1'b1);

    // Test 6: reset mid-frame discards a pending load.
    wait_frame_done();
    step(2);
    value = 16'h9999; digit_en = 4'hF; dp_in = 4'hF; load = 1'b1;
    step(1);
    load = 1'b0;
    check("rst_pend_set", 16'(dut.r_pend_valid), 16'h1);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_digit("rst_mid", 4'hF, 7'h7F, 1'b1);
    check("rst_mid_idx", 16'(digit_idx), 16'h0);
    check("rst_mid_pend", 16'(dut.r_pend_valid), 16'h0);
    check("rst_mid_fd1", 16'(frame_done1), 16'h0);
    wait_frame_done();
    step(1);
    check_digit("rst_after_d0", 4'hF, 7'h7F, 1'b1);
    step(4);
    check_digit("rst_after_d1", 4'hF, 7'h7F, 1'b1);

    // Test 7: leading zeros (blanked only when the feature is built in).
    value = 16'h0050; digit_en = 4'hF; dp_in = 4'h0; load = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame_done();
    step(1);
    check_digit("lz_d0", 4'b1110, 7'h40, 1'b1);
    step(4);
    check_digit("lz_d1", 4'b1101, 7'h12, 1'b1);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    step(4);
    check_digit("lz_d2", 4'b1111, 7'h7F, 1'b1);
    step(4);
    check_digit("lz_d3", 4'b1111, 7'h7F, 1'b1);
`else
    step(4);
    check_digit("lz_d2", 4'b1011, 7'h40, 1'b1);
    step(4);
    check_digit("lz_d3", 4'b0111, 7'h40, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
